// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX stage and later RX work.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE  = 0;
  localparam int unsigned PAR_EVEN  = 1;
  localparam int unsigned PAR_ODD   = 2;
  localparam int unsigned DATA_BITS = 8;

  // Parity bit over a data byte; odd mode inverts the even result.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int unsigned mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head-of-queue read port.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_stage.sv
// Buffered UART transmitter: valid/ready byte input, 8N1 or 8E1/8O1 serial output.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e  state;
  logic [TW-1:0] timer;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       par_bit;
  logic       bit_done;

  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready depends on occupancy only, so a full FIFO never bypasses into the shifter.
  assign in_ready  = !rst && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign bit_done  = (timer == '0);

  // A byte is popped when idle, or at the end of a stop bit to chain frames gap-free.
  always_comb begin
    fifo_pop = 1'b0;
    if (!rst && !fifo_empty) begin
      if (state == IDLE)                fifo_pop = 1'b1;
      else if (state == STOP && bit_done) fifo_pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shreg   <= fifo_rdata;
            par_bit <= parity_bit(fifo_rdata, PARITY);
            timer   <= BIT_LAST;
            state   <= START;
            tx      <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            timer   <= BIT_LAST;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else begin
            timer <= timer - TW'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            timer <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                state <= uart_pkg::PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end

        uart_pkg::PARITY: begin
          if (bit_done) begin
            state <= STOP;
            timer <= BIT_LAST;
            tx    <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            if (fifo_pop) begin
              shreg   <= fifo_rdata;
              par_bit <= parity_bit(fifo_rdata, PARITY);
              timer   <= BIT_LAST;
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Bench for uart_tx_stage: three parity variants share stimulus, each checked cycle by cycle against a frame-level model.
module tb_uart_tx_stage;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial value of bit slot idx of a frame: start, 8 data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned idx, input int unsigned par);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && par != 0) return (^d) ^ (par == 2);
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int unsigned PAR = g;
    localparam int unsigned FL  = ((PAR != 0) ? 11 : 10) * CPB;

    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    uart_tx_stage #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .PARITY       (PAR)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
    );

    logic [7:0]  mq [$];
    logic        active = 1'b0;
    int unsigned pos    = 0;
    logic [7:0]  cur    = 8'h00;

    // Model: a queue of accepted bytes and the position inside the frame on the wire.
    always @(posedge clk) begin
      logic take;
      logic can_pop;
      logic exp_tx;
      if (rst) begin
        mq.delete();
        active = 1'b0;
        pos    = 0;
      end else begin
        take    = in_valid && (mq.size() != DEPTH);
        can_pop = (mq.size() != 0);
        if (active && pos != FL - 1) begin
          pos++;
        end else if (can_pop) begin
          cur    = mq.pop_front();
          pos    = 0;
          active = 1'b1;
        end else begin
          active = 1'b0;
        end
        if (take) mq.push_back(in_data);
      end
      #1;
      exp_tx = active ? frame_bit(cur, pos / CPB, PAR) : 1'b1;
      check_eq($sformatf("lane%0d tx", g), 32'(tx), 32'(exp_tx));
      check_eq($sformatf("lane%0d busy", g), 32'(busy), 32'(active || mq.size() != 0));
      check_eq($sformatf("lane%0d fifo_count", g), 32'(fifo_count), 32'(mq.size()));
      check_eq($sformatf("lane%0d in_ready", g), 32'(in_ready), 32'(!rst && mq.size() != DEPTH));
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single bytes, including parity corner values.
    drive(1'b1, 8'hA5);
    idle(60);
    drive(1'b1, 8'h00);
    idle(60);

    // Back-to-back; the second push lands on the idle pop edge.
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h0F);
    idle(110);

    // Backpressure: eight consecutive valid cycles against a depth-4 buffer.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom));
    idle(300);

    // Reset during data bit 3 with two bytes still queued.
    drive(1'b1, 8'hC3);
    drive(1'b1, 8'h3C);
    drive(1'b1, 8'h99);
    idle(16);
    @(negedge clk);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(60);

    // Random traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      rst      = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
